// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, constants and address decode helpers for the memory bus slave
package bus_pkg;

  // Two-state transfer FSM: IDLE accepts a request, WAIT counts wait states down to completion.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_state_e;

  localparam int          WORD_BYTES   = 4;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  // True when addr falls inside the 4*2**aw byte window starting at base.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned aw);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> (aw + 2)) == 32'd0);
  endfunction

  // Word index relative to base; the byte-offset bits are dropped so misaligned
  // addresses land on their containing word.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return {2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// rtl/bus_mem_array.sv - word-organised RAM with byte-lane writes and one registered read port
module bus_mem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  input  logic                  i_re,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [31:0] r_rdata;

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Synchronous read, refreshed only when the controller asks for it.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_slave.sv
// rtl/bus_mem_slave.sv - memory-side bus slave with wait-state generator and error flag
module bus_mem_slave
  import bus_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic [3:0]  stall_extra,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);

  // Counter must hold WAIT_CYCLES-1+15 without wrapping.
  localparam int CNT_W = $clog2(WAIT_CYCLES + 16);

  if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
    $error("bus_mem_slave: WAIT_CYCLES must be >= 1");
  end

  bus_state_e             r_state;
  bus_state_e             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rd_ok;
  logic                   r_err;

  logic                   w_req;
  logic                   w_both;
  logic                   w_in_range;
  logic                   w_misaligned;
  logic [ADDR_WIDTH-1:0]  w_idx;
  logic                   w_load;
  logic                   w_done;
  logic                   w_commit;
  logic [3:0]             w_we;
  logic [31:0]            w_rdata;

  assign w_req        = read | write;
  assign w_both       = read & write;
  assign w_in_range   = addr_in_range(address, BASE_ADDR, ADDR_WIDTH);
  assign w_misaligned = (address[1:0] != 2'b00);
  assign w_idx        = ADDR_WIDTH'(word_index(address, BASE_ADDR));

  // State register; an asynchronous reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, waitrequest and the per-edge load/commit strobes.
  always_comb begin
    w_state_nxt = r_state;
    waitrequest = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        waitrequest = w_req;
        if (w_req) begin
          w_state_nxt = WAIT;
          w_load      = 1'b1;
        end
      end
      WAIT: begin
        waitrequest = w_req && (r_cnt != '0);
        if (!w_req) begin
          // Master withdrew the request: abandon quietly.
          w_state_nxt = IDLE;
        end else if (r_cnt != '0) begin
          // Keep readdata tracking the live address while waiting.
          w_load = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
          w_commit    = write && !read && w_in_range;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down each WAIT edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && w_req) begin
      r_cnt <= CNT_W'(WAIT_CYCLES - 1) + CNT_W'(stall_extra);
    end else if (r_state == WAIT && w_req && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (w_state_nxt == IDLE) begin
      r_cnt <= '0;
    end
  end

  // Qualifier for the array read register: out-of-range and read+write give zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ok <= 1'b0;
    end else if (w_load) begin
      r_rd_ok <= w_in_range && !w_both;
    end
  end

  // Sticky error flag, judged on the values present at completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_done && (!w_in_range || w_misaligned || w_both)) begin
      r_err <= 1'b1;
    end
  end

  assign w_we = w_commit ? byteenable : 4'b0000;

  bus_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (writedata),
    .i_re    (w_load),
    .o_rdata (w_rdata)
  );

  assign readdata = r_rd_ok ? w_rdata : 32'h0;
  assign err      = r_err;

endmodule
